// File: rtl/ip_tx_arbiter.sv
// Round-robin scheduler sharing the IP transmit engine between the UDP and ICMP transmitters,
// with a watchdog that recovers from packets the engine drops without an end strobe.
module ip_tx_arbiter #(
    parameter logic [7:0]  UDP_TYPE  = 8'h11,
    parameter logic [7:0]  ICMP_TYPE = 8'h01,
    parameter int unsigned WDOG_W    = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        udp_tx_req,
    input  logic        icmp_tx_req,
    input  logic [15:0] udp_send_data_length,
    input  logic [15:0] icmp_send_data_length,
    input  logic        udp_tx_ready,
    input  logic        icmp_tx_ready,
    input  logic [7:0]  udp_tx_data,
    input  logic [7:0]  icmp_tx_data,
    output logic        udp_tx_ack,
    output logic        icmp_tx_ack,
    output logic        udp_data_req,
    output logic        icmp_data_req,
    output logic        udp_tx_end,
    output logic        icmp_tx_end,
    output logic        ip_tx_req,
    input  logic        ip_tx_ack,
    output logic [7:0]  ip_send_type,
    output logic [15:0] ip_send_data_length,
    output logic [7:0]  upper_layer_data,
    output logic        upper_tx_ready,
    input  logic        upper_data_req,
    input  logic        ip_tx_end,
    output logic        arb_busy,
    output logic        arb_abort
);
    typedef enum logic [3:0] {
        StIdle  = 4'b0001,
        StGrant = 4'b0010,
        StSend  = 4'b0100,
        StDone  = 4'b1000
    } state_e;

    // sel/last_grant encoding: 0 = UDP, 1 = ICMP
    state_e            state_q, state_d;
    logic              sel_q, sel_d;
    logic              last_q, last_d;
    logic              req_q, req_d;
    logic              udp_ack_q, udp_ack_d;
    logic              icmp_ack_q, icmp_ack_d;
    logic              abort_q, abort_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              wdog_exp;

    assign wdog_exp = &wdog_q;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_d     = last_q;
        req_d      = req_q;
        udp_ack_d  = 1'b0;
        icmp_ack_d = 1'b0;
        abort_d    = 1'b0;
        wdog_d     = '0;
        unique case (state_q)
            StIdle: begin
                if (udp_tx_req || icmp_tx_req) begin
                    // On a tie the side that did not go last wins
                    sel_d   = (udp_tx_req && icmp_tx_req) ? ~last_q : icmp_tx_req;
                    req_d   = 1'b1;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                wdog_d = wdog_q + WDOG_W'(1);
                if (wdog_exp) begin
                    abort_d = 1'b1;
                    req_d   = 1'b0;
                    last_d  = sel_q;
                    wdog_d  = '0;
                    state_d = StIdle;
                end else if (ip_tx_ack) begin
                    req_d      = 1'b0;
                    udp_ack_d  = ~sel_q;
                    icmp_ack_d = sel_q;
                    state_d    = StSend;
                end
            end
            StSend: begin
                wdog_d = wdog_q + WDOG_W'(1);
                if (ip_tx_end) begin
                    state_d = StDone;
                end else if (wdog_exp) begin
                    abort_d = 1'b1;
                    last_d  = sel_q;
                    wdog_d  = '0;
                    state_d = StIdle;
                end
            end
            StDone: begin
                last_d  = sel_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            sel_q      <= 1'b0;
            last_q     <= 1'b0;
            req_q      <= 1'b0;
            udp_ack_q  <= 1'b0;
            icmp_ack_q <= 1'b0;
            abort_q    <= 1'b0;
            wdog_q     <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            req_q      <= req_d;
            udp_ack_q  <= udp_ack_d;
            icmp_ack_q <= icmp_ack_d;
            abort_q    <= abort_d;
            wdog_q     <= wdog_d;
        end
    end

    assign ip_tx_req   = req_q;
    assign udp_tx_ack  = udp_ack_q;
    assign icmp_tx_ack = icmp_ack_q;
    assign arb_abort   = abort_q;
    assign arb_busy    = (state_q != StIdle);

    // Zero-latency routing between the engine and the selected requester
    always_comb begin
        ip_send_type        = 8'h00;
        ip_send_data_length = 16'h0000;
        upper_layer_data    = 8'h00;
        upper_tx_ready      = 1'b0;
        udp_data_req        = 1'b0;
        icmp_data_req       = 1'b0;
        udp_tx_end          = 1'b0;
        icmp_tx_end         = 1'b0;
        if (state_q != StIdle) begin
            if (sel_q) begin
                ip_send_type        = ICMP_TYPE;
                ip_send_data_length = icmp_send_data_length;
                upper_layer_data    = icmp_tx_data;
                upper_tx_ready      = icmp_tx_ready;
                icmp_data_req       = upper_data_req;
                icmp_tx_end         = ip_tx_end;
            end else begin
                ip_send_type        = UDP_TYPE;
                ip_send_data_length = udp_send_data_length;
                upper_layer_data    = udp_tx_data;
                upper_tx_ready      = udp_tx_ready;
                udp_data_req        = upper_data_req;
                udp_tx_end          = ip_tx_end;
            end
        end
    end
endmodule

// File: doc/ip_tx_arbiter.md
# ip_tx_arbiter

Two-requester scheduler in front of the IP transmit engine: shares the single IPv4 header/frame builder between the UDP transmitter and the ICMP (echo reply) transmitter. It grants one requester at a time with round-robin fairness and sequences the engine's request/ack handshake. It routes the selected requester's length, protocol type, payload bytes and ready/data-request/end strobes to and from the engine. A watchdog recovers from packets the engine silently drops on its internal timeout.

## Interface
- UDP_TYPE, 8'h11, IP protocol field driven while UDP is granted
- ICMP_TYPE, 8'h01, IP protocol field driven while ICMP is granted
- WDOG_W, 20, watchdog counter width; abort at all-ones (2^WDOG_W-1 cycles)

- clk  in  1  single clock for all logic
- rst  in  1  reset, synchronous, active-high
- udp_tx_req / icmp_tx_req  in  1  packet request, level, held until matching ack
- udp_send_data_length / icmp_send_data_length  in  16  IP total length for the packet
- udp_tx_ready / icmp_tx_ready  in  1  requester has payload staged
- udp_tx_data / icmp_tx_data  in  8  payload byte stream
- udp_tx_ack / icmp_tx_ack  out  1  one-cycle pulse: request accepted by engine
- udp_data_req / icmp_data_req  out  1  engine payload request, routed to granted side
- udp_tx_end / icmp_tx_end  out  1  engine end-of-packet pulse, routed to granted side
- ip_tx_req  out  1  request to engine
- ip_tx_ack  in  1  engine accept
- ip_send_type  out  8  protocol field to engine
- ip_send_data_length  out  16  length to engine
- upper_layer_data  out  8  payload to engine
- upper_tx_ready  out  1  payload ready to engine
- upper_data_req  in  1  engine payload request
- ip_tx_end  in  1  engine end-of-packet
- arb_busy  out  1  high in every state except IDLE
- arb_abort  out  1  one-cycle pulse on watchdog expiry

## Operation
- States: IDLE, GRANT, SEND, DONE; one-hot, registered.
- IDLE: if exactly one req is high, select it. If both are high, select the side not in last_grant. last_grant resets to UDP, so ICMP wins the first tie. On any req, latch sel and go to GRANT.
- GRANT: ip_tx_req = 1 (registered). On ip_tx_ack, pulse the selected *_tx_ack on the next cycle, drop ip_tx_req and go to SEND.
- SEND: wait for ip_tx_end, then go to DONE.
- DONE: one cycle. Update last_grant <= sel, then go to IDLE. A requester must drop req in the cycle it sees its ack. A req still high in IDLE is a new packet.
- Routing (combinational from sel, gated by state != IDLE):
  - ip_send_type, ip_send_data_length, upper_layer_data and upper_tx_ready come from the selected side.
  - upper_data_req and ip_tx_end go only to the selected side's *_data_req / *_tx_end.
  - The non-selected side sees 0 on all routed outputs.
  - In IDLE all routed outputs are 0.
- Watchdog: counter clears in IDLE/DONE and increments in GRANT and SEND. At all-ones: pulse arb_abort, force ip_tx_req low, set last_grant <= sel, go to IDLE. No *_tx_end is generated. The default exceeds the engine's 16-bit internal timeout.
- Length and type stay stable from GRANT entry to DONE exit, because sel changes only in IDLE.
- A request change on the non-selected side while busy has no effect until IDLE.

## Timing
- Reset (rst high at a clock edge): state IDLE, sel = 0, last_grant = UDP, watchdog 0.
  - Reset outputs: ip_tx_req, *_tx_ack, arb_busy and arb_abort = 0; all routed outputs = 0.
  - Reset mid-packet aborts immediately with no end or ack pulse.
- Req high at edge N in IDLE:
  - State is GRANT after edge N+1; ip_tx_req and arb_busy are high from N+1.
- ip_tx_ack sampled high at edge M:
  - *_tx_ack is high for exactly cycle M+1; ip_tx_req is low from M+1.
- Routed strobes add zero latency: same-cycle pass-through of data_req, data, ready and end.
- ip_tx_end at edge E: DONE after E+1, IDLE after E+2. The earliest next ip_tx_req is E+3.
- Simultaneous ip_tx_ack and watchdog expiry: watchdog wins. Abort is taken and no ack is forwarded.

## Test plan
- UDP only, length 16'd60: ip_send_type 8'h11 and length 60 from GRANT. udp_tx_ack is one cycle after ip_tx_ack. udp_tx_end follows ip_tx_end; icmp outputs stay 0 throughout.
- Both requesters assert in the same cycle after reset: ICMP granted first (type 8'h01). UDP is granted next after DONE.
- Both requesters hold req continuously over 4 packets: grants alternate ICMP, UDP, ICMP, UDP.
- Payload routing during SEND with icmp selected: upper_data_req pulses reach only icmp_data_req. upper_layer_data equals icmp_tx_data byte for byte, e.g. 8'hA5 then 8'h5A.
- Engine never asserts ip_tx_end (WDOG_W=8 in test): arb_abort pulses after 255 cycles and the state returns to IDLE. The other requester wins the next tie.
- rst asserted mid-SEND: next cycle all outputs are 0 and the state is IDLE. A following UDP request completes normally.
